key_event_queue: RTL and testbench

//  Parametrised successor to the fixed 22-key PS/2 pulse mapper. Maps decoder scan codes to key

---
 rtl/key_event_queue.sv | 156 +++++++++++++++
 tb/tb_key_event_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// Scan-code to key-index mapper with typematic repeat and event FIFO.
// Sits between the PS/2 decoder and the entry FSMs.
module key_event_queue #(
  parameter int NUM_KEYS = 22,
  parameter logic [NUM_KEYS*9-1:0] KEY_TABLE = {
    9'h172, 9'h175, 9'h029, 9'h00D,
    9'h076, 9'h071, 9'h14A, 9'h07C,
    9'h07B, 9'h079, 9'h066, 9'h05A,
    9'h07D, 9'h075, 9'h06C, 9'h074,
    9'h073, 9'h06B, 9'h07A, 9'h072,
    9'h069, 9'h070
  },
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int EMIT_RELEASE  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [8:0] last_change,
  input  logic       key_is_down,
  input  logic       evt_ready,
  input  logic       clr_ovf,
  output logic       evt_valid,
  output logic [5:0] evt_idx,
  output logic       evt_repeat,
  output logic       evt_release,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] DLY_LD = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PER_LD = 32'(REPEAT_PERIOD - 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic REN  = (REPEAT_EN != 0);
  localparam logic EREL = (EMIT_RELEASE != 0);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  logic       hit;
  logic [5:0] hit_idx;

  // Scan downwards so the lowest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_TABLE[9*i +: 9] == last_change) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
    end
  end

  rpt_state_t  state;
  logic [5:0]  held;
  logic [31:0] cnt;

  logic kv_evt;
  logic press;
  logic release_k;
  logic rel_held;
  logic expire;
  logic rep_fire;

  assign kv_evt    = key_valid & hit;
  assign press     = kv_evt & key_is_down;
  assign release_k = kv_evt & ~key_is_down;
  assign rel_held  = release_k & (state != IDLE)
                   & (hit_idx == held);
  assign expire    = (state != IDLE) & (cnt == '0);
  assign rep_fire  = expire & ~kv_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      held  <= '0;
      cnt   <= '0;
    end else if (press && REN) begin
      state <= DELAY;
      held  <= hit_idx;
      cnt   <= DLY_LD;
    end else if (rel_held) begin
      state <= IDLE;
      held  <= '0;
      cnt   <= '0;
    end else if (expire) begin
      state <= REPEAT;
      cnt   <= PER_LD;
    end else if (state != IDLE) begin
      cnt   <= cnt - 1'b1;
    end
  end

  logic       push;
  logic [7:0] push_data;

  assign push = press | (release_k & EREL) | rep_fire;

  always_comb begin
    if (kv_evt) push_data = {~key_is_down, 1'b0, hit_idx};
    else        push_data = {1'b0, 1'b1, held};
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign full  = (count == FULL_CNT);
  assign pop   = evt_valid & evt_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  logic [7:0] head;

  assign head        = mem[rd_ptr];
  assign evt_valid   = (count != '0);
  assign evt_idx     = evt_valid ? head[5:0] : '0;
  assign evt_repeat  = evt_valid & head[6];
  assign evt_release = evt_valid & head[7];

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: vector table plus repeat/FIFO sequences,
// events checked against a scoreboard of expected {idx,rep,rel,cycle}.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [8:0] last_change;
  logic       key_is_down;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [5:0] evt_idx;
  logic       evt_repeat;
  logic       evt_release;
  logic       overflow;

  key_event_queue #(
    .FIFO_DEPTH   (4),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .EMIT_RELEASE (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .last_change(last_change),
    .key_is_down(key_is_down),
    .evt_ready  (evt_ready),
    .clr_ovf    (clr_ovf),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_repeat (evt_repeat),
    .evt_release(evt_release),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] code;
    logic       down;
    logic       exp;
    logic [5:0] idx;
  } vec_t;

  typedef struct {
    logic [5:0] idx;
    logic       rep;
    logic       rel;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [5:0] idx,
                           input logic rep,
                           input logic rel,
                           input int c);
    ev_t e;
    e.idx = idx;
    e.rep = rep;
    e.rel = rel;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Inputs are already set; a pop this cycle is checked, then one edge.
  task automatic cycle();
    ev_t e;
    if (evt_valid && evt_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event idx=%0d rep=%0b rel=%0b cyc=%0d",
                 evt_idx, evt_repeat, evt_release, cyc);
      end else begin
        e = sb.pop_front();
        if (evt_idx !== e.idx || evt_repeat !== e.rep ||
            evt_release !== e.rel ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          failures++;
          $display("FAIL event got=%0d/%0b/%0b@%0d exp=%0d/%0b/%0b@%0d",
                   evt_idx, evt_repeat, evt_release, cyc,
                   e.idx, e.rep, e.rel, e.cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic kv(input logic [8:0] code, input logic down);
    key_valid   = 1'b1;
    last_change = code;
    key_is_down = down;
    cycle();
    key_valid   = 1'b0;
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_valid"}, 32'(evt_valid), 32'd0);
    chk({nm, "_sb"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vt[12];
  int   p;

  initial begin
    vt[0]  = '{9'h070, 1'b1, 1'b1, 6'd0};
    vt[1]  = '{9'h070, 1'b0, 1'b1, 6'd0};
    vt[2]  = '{9'h015, 1'b1, 1'b0, 6'd0};
    vt[3]  = '{9'h015, 1'b0, 1'b0, 6'd0};
    vt[4]  = '{9'h069, 1'b1, 1'b1, 6'd1};
    vt[5]  = '{9'h069, 1'b0, 1'b1, 6'd1};
    vt[6]  = '{9'h172, 1'b1, 1'b1, 6'd21};
    vt[7]  = '{9'h172, 1'b0, 1'b1, 6'd21};
    vt[8]  = '{9'h170, 1'b1, 1'b0, 6'd0};
    vt[9]  = '{9'h05A, 1'b1, 1'b1, 6'd10};
    vt[10] = '{9'h05A, 1'b0, 1'b1, 6'd10};
    vt[11] = '{9'h072, 1'b0, 1'b1, 6'd2};

    rst         = 1'b1;
    key_valid   = 1'b0;
    last_change = '0;
    key_is_down = 1'b0;
    evt_ready   = 1'b0;
    clr_ovf     = 1'b0;
    #3;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_outs", {evt_idx, evt_repeat, evt_release}, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Single press/release vectors, consumer always ready
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (vt[i].exp)
        expect_ev(vt[i].idx, 1'b0, ~vt[i].down, cyc + 1);
      kv(vt[i].code, vt[i].down);
      idle(1);
    end
    idle(3);
    chk_empty("vectors");

    // Held key: repeats at +8 then every 4, release stops them
    p = cyc + 1;
    expect_ev(6'd10, 1'b0, 1'b0, p);
    for (int k = 8; k <= 28; k += 4)
      expect_ev(6'd10, 1'b1, 1'b0, p + k);
    expect_ev(6'd10, 1'b0, 1'b1, p + 30);
    kv(9'h05A, 1'b1);
    idle(29);
    kv(9'h05A, 1'b0);
    idle(12);
    chk_empty("repeat");

    // A then B: B repeats; A release ignored; key_valid at expiry
    p = cyc + 1;
    expect_ev(6'd0, 1'b0, 1'b0, p);
    expect_ev(6'd1, 1'b0, 1'b0, p + 2);
    expect_ev(6'd0, 1'b0, 1'b1, p + 4);
    expect_ev(6'd1, 1'b1, 1'b0, p + 10);
    expect_ev(6'd1, 1'b1, 1'b0, p + 14);
    expect_ev(6'd2, 1'b0, 1'b1, p + 18);
    expect_ev(6'd1, 1'b1, 1'b0, p + 22);
    expect_ev(6'd1, 1'b0, 1'b1, p + 24);
    kv(9'h070, 1'b1);
    idle(1);
    kv(9'h069, 1'b1);
    idle(1);
    kv(9'h070, 1'b0);
    idle(13);
    kv(9'h072, 1'b0);
    idle(5);
    kv(9'h069, 1'b0);
    idle(10);
    chk_empty("latest_key");

    // Overflow: 5 presses into a depth-4 FIFO with no consumer
    evt_ready = 1'b0;
    expect_ev(6'd0, 1'b0, 1'b0, -1);
    expect_ev(6'd1, 1'b0, 1'b0, -1);
    expect_ev(6'd2, 1'b0, 1'b0, -1);
    expect_ev(6'd3, 1'b0, 1'b0, -1);
    kv(9'h070, 1'b1); idle(1);
    kv(9'h069, 1'b1); idle(1);
    kv(9'h072, 1'b1); idle(1);
    chk("ovf_before_full", 32'(overflow), 32'd0);
    kv(9'h07A, 1'b1); idle(1);
    kv(9'h06B, 1'b1); idle(1);
    kv(9'h06B, 1'b0); idle(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    idle(6);
    chk_empty("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with pop and push in the same cycle
    evt_ready = 1'b0;
    expect_ev(6'd0, 1'b0, 1'b0, -1);
    expect_ev(6'd0, 1'b0, 1'b1, -1);
    expect_ev(6'd1, 1'b0, 1'b0, -1);
    expect_ev(6'd1, 1'b0, 1'b1, -1);
    kv(9'h070, 1'b1);
    kv(9'h070, 1'b0);
    kv(9'h069, 1'b1);
    kv(9'h069, 1'b0);
    expect_ev(6'd3, 1'b0, 1'b0, -1);
    evt_ready = 1'b1;
    kv(9'h07A, 1'b1);
    evt_ready = 1'b0;
    chk("popush_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    expect_ev(6'd3, 1'b0, 1'b1, -1);
    kv(9'h07A, 1'b0);
    idle(8);
    chk_empty("popush_drain");

    // Reset mid-repeat with a full FIFO and overflow set
    evt_ready = 1'b0;
    kv(9'h05A, 1'b1);
    idle(21);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    cycle();
    rst = 1'b0;
    evt_ready = 1'b1;
    idle(20);
    chk_empty("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
